rgb16to32: RTL

RGB16TO32 -- requirements
Module: rgb16to32

---
 rtl/rgb_pkg.sv | 28 ++
 rtl/nasti_stream_channel.sv | 27 ++
 rtl/rgb565to888.sv | 25 ++
 rtl/rgb16to32.sv | 105 ++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB565 -> XRGB8888 stream converter.
package rgb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  // RGB565 field positions
  localparam int unsigned R565_MSB = 15;
  localparam int unsigned R565_LSB = 11;
  localparam int unsigned G565_MSB = 10;
  localparam int unsigned G565_LSB = 5;
  localparam int unsigned B565_MSB = 4;
  localparam int unsigned B565_LSB = 0;

  // XRGB8888 field positions
  localparam int unsigned X888_MSB = 31;
  localparam int unsigned X888_LSB = 24;
  localparam int unsigned R888_MSB = 23;
  localparam int unsigned R888_LSB = 16;
  localparam int unsigned G888_MSB = 15;
  localparam int unsigned G888_LSB = 8;
  localparam int unsigned B888_MSB = 7;
  localparam int unsigned B888_LSB = 0;

endpackage

// File: rtl/nasti_stream_channel.sv
// AXI-stream style channel bundle with master/slave views.
interface nasti_stream_channel #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 1
);
  logic                    t_valid;
  logic                    t_ready;
  logic [DATA_WIDTH-1:0]   t_data;
  logic [DATA_WIDTH/8-1:0] t_strb;
  logic [DATA_WIDTH/8-1:0] t_keep;
  logic                    t_last;
  logic [ID_WIDTH-1:0]     t_id;
  logic [DEST_WIDTH-1:0]   t_dest;
  logic [USER_WIDTH-1:0]   t_user;

  modport master (
    output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    output t_ready
  );
endinterface

// File: rtl/rgb565to888.sv
// Combinational expansion of one RGB565 pixel to XRGB8888 by MSB replication.
module rgb565to888
  import rgb_pkg::*;
(
  input  logic [15:0] rgb565,
  output logic [31:0] xrgb
);

  logic [4:0] r5;
  logic [5:0] g6;
  logic [4:0] b5;

  // Split the fields and widen each by repeating its top bits into the LSBs
  always_comb begin
    r5   = rgb565[R565_MSB:R565_LSB];
    g6   = rgb565[G565_MSB:G565_LSB];
    b5   = rgb565[B565_MSB:B565_LSB];
    xrgb = '0;
    xrgb[X888_MSB:X888_LSB] = 8'h00;
    xrgb[R888_MSB:R888_LSB] = {r5, r5[4:2]};
    xrgb[G888_MSB:G888_LSB] = {g6, g6[5:4]};
    xrgb[B888_MSB:B888_LSB] = {b5, b5[4:2]};
  end

endmodule

// File: rtl/rgb16to32.sv
// RGB565 (4 px/beat) to XRGB8888 (2 px/beat) stream width converter.
module rgb16to32
  import rgb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic               aclk,
  input  logic               areset,
  nasti_stream_channel.slave  src,
  nasti_stream_channel.master dst
);

  localparam int unsigned HALF = DATA_WIDTH / 2;

  state_t                state_q;
  state_t                state_d;
  logic                  capture;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;
  logic [HALF-1:0]       half;
  logic [31:0]           px0;
  logic [31:0]           px1;
  logic                  unused_src;

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; capture marks a src handshake
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (src.t_valid) begin
          capture = 1'b1;
          state_d = LO;
        end
      end
      LO: begin
        if (dst.t_ready) state_d = HI;
      end
      HI: begin
        if (dst.t_ready) begin
          if (src.t_valid) begin
            capture = 1'b1;
            state_d = LO;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Held beat and its last flag
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      data_q <= '0;
      last_q <= 1'b0;
    end else if (capture) begin
      data_q <= src.t_data;
      last_q <= src.t_last;
    end
  end

  // Select the half of the held beat that is currently presented
  always_comb begin
    half = (state_q == HI) ? data_q[DATA_WIDTH-1:HALF] : data_q[HALF-1:0];
  end

  rgb565to888 u_px0 (
    .rgb565 (half[15:0]),
    .xrgb   (px0)
  );

  rgb565to888 u_px1 (
    .rgb565 (half[31:16]),
    .xrgb   (px1)
  );

  // Stream handshakes and constant sideband fields
  always_comb begin
    src.t_ready = !areset && ((state_q == IDLE) || ((state_q == HI) && dst.t_ready));
    dst.t_valid = (state_q != IDLE);
    dst.t_data  = {px1, px0};
    dst.t_last  = (state_q == HI) && last_q;
    dst.t_strb  = '1;
    dst.t_keep  = '1;
    dst.t_id    = '0;
    dst.t_dest  = DEST_WIDTH'(0);
    dst.t_user  = USER_WIDTH'(0);
  end

  // src sideband fields carry no meaning for this converter
  always_comb begin
    unused_src = ^{src.t_strb, src.t_keep, src.t_id, src.t_dest, src.t_user};
  end

endmodule
